// File: rtl/tartaruga_pkg.sv
// -----------------------------------------------------------------------------
// tartaruga_pkg
// Shared types and constants for the memory-stage store buffer.
//   bus32_t             : 32-bit address/data word
//   STORE_BUFFER_ENTRIES: store buffer depth (4)
//   store_buffer_idx_t  : entry index, $clog2(depth) bits
//   exe_to_mem_t        : execute-to-memory pipeline bundle
//   sb_state_t          : per-entry lifecycle state
//   sb_entry_t          : per-entry storage (state, address, data)
// -----------------------------------------------------------------------------
package tartaruga_pkg;

    typedef logic [31:0] bus32_t;

    localparam int STORE_BUFFER_ENTRIES = 4;
    localparam int STORE_BUFFER_IDX_W   = $clog2(STORE_BUFFER_ENTRIES);

    typedef logic [STORE_BUFFER_IDX_W-1:0] store_buffer_idx_t;

    // Occupancy needs one extra bit so that "full" (4) is representable.
    typedef logic [STORE_BUFFER_IDX_W:0] sb_count_t;

    localparam sb_count_t SB_COUNT_FULL  = 3'd4;
    localparam sb_count_t SB_COUNT_EMPTY = 3'd0;

    typedef struct packed {
        bus32_t     pc;
        logic [4:0] rd;
        logic       mem_we;
        logic [1:0] mem_size;
    } exe_to_mem_t;

    typedef enum logic [1:0] {
        SB_FREE      = 2'd0,
        SB_PENDING   = 2'd1,
        SB_COMMITTED = 2'd2,
        SB_DISCARDED = 2'd3
    } sb_state_t;

    typedef struct packed {
        sb_state_t state;
        bus32_t    addr;
        bus32_t    data;
    } sb_entry_t;

    localparam sb_entry_t SB_ENTRY_RESET = '{state: SB_FREE, addr: 32'h0000_0000, data: 32'h0000_0000};

    // Circular increment; the index width makes 3 -> 0 wrap implicit.
    function automatic store_buffer_idx_t sb_idx_inc(input store_buffer_idx_t idx);
        return idx + store_buffer_idx_t'(1'b1);
    endfunction

endpackage : tartaruga_pkg

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// In-order circular buffer holding speculative stores until the commit stage
// resolves each one. Committed entries drain to data memory strictly in
// allocation order; discarded entries are dropped without a write.
//
// Ports:
//   clk_i                      : clock, rising edge
//   rstn_i                     : asynchronous active-low reset
//   exe_to_mem_i               : execute-to-memory bundle (not used for outputs)
//   data_i / addr_i            : store data / address to allocate
//   req_valid_i / req_ready_o  : allocation handshake (ready = not full)
//   addr_o / data_wr_o         : memory write address / data (head entry)
//   rsp_valid_o / rsp_ready_i  : memory write handshake
//   store_buffer_commit_i      : commit strobe, target store_buffer_idx_commit_i
//   store_buffer_discard_i     : discard strobe, target store_buffer_idx_discard_i
// -----------------------------------------------------------------------------
module store_buffer
    import tartaruga_pkg::*;
(
    input  logic              clk_i,
    input  logic              rstn_i,
    input  exe_to_mem_t       exe_to_mem_i,
    input  bus32_t            data_i,
    input  bus32_t            addr_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    output bus32_t            addr_o,
    output bus32_t            data_wr_o,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    input  logic              store_buffer_commit_i,
    input  store_buffer_idx_t store_buffer_idx_commit_i,
    input  logic              store_buffer_discard_i,
    input  store_buffer_idx_t store_buffer_idx_discard_i
);

    sb_entry_t         entries_q [STORE_BUFFER_ENTRIES];
    sb_entry_t         entries_d [STORE_BUFFER_ENTRIES];
    store_buffer_idx_t head_q, head_d;
    store_buffer_idx_t tail_q, tail_d;
    sb_count_t         count_q, count_d;

    sb_entry_t head_entry_s;
    logic      not_full_s;
    logic      alloc_s;
    logic      drain_free_s;
    logic      commit_hit_s;
    logic      discard_hit_s;

    // The execute bundle carries nothing this revision acts on; fold it to one
    // bit so the port remains referenced without influencing any state.
    logic exe_unused_s;
    assign exe_unused_s = ^exe_to_mem_i;

    // Head decode: drain handshake, write port outputs and allocation gating.
    always_comb begin
        head_entry_s = entries_q[head_q];
        not_full_s   = (count_q != SB_COUNT_FULL);
        req_ready_o  = not_full_s;
        alloc_s      = req_valid_i && not_full_s;
        rsp_valid_o  = 1'b0;
        addr_o       = 32'h0000_0000;
        data_wr_o    = 32'h0000_0000;
        drain_free_s = 1'b0;
        case (head_entry_s.state)
            SB_COMMITTED: begin
                rsp_valid_o  = 1'b1;
                addr_o       = head_entry_s.addr;
                data_wr_o    = head_entry_s.data;
                drain_free_s = rsp_ready_i;
            end
            // A discarded head retires silently in a single cycle.
            SB_DISCARDED: begin
                drain_free_s = 1'b1;
            end
            // A pending head blocks every younger entry, committed or not.
            SB_PENDING: begin
                drain_free_s = 1'b0;
            end
            SB_FREE: begin
                drain_free_s = 1'b0;
            end
            default: begin
                drain_free_s = 1'b0;
            end
        endcase
    end

    // Commit/discard qualification: only a PENDING entry that is not the one
    // being allocated this cycle can be resolved.
    always_comb begin
        commit_hit_s  = store_buffer_commit_i
                     && (entries_q[store_buffer_idx_commit_i].state == SB_PENDING)
                     && !(alloc_s && (store_buffer_idx_commit_i == tail_q));
        discard_hit_s = store_buffer_discard_i
                     && (entries_q[store_buffer_idx_discard_i].state == SB_PENDING)
                     && !(alloc_s && (store_buffer_idx_discard_i == tail_q));
    end

    // Per-entry next state. Draining head, allocating tail and commit/discard
    // targets never collide: head/tail are non-PENDING here whenever they act,
    // and discard is checked before commit so it wins on the same entry.
    always_comb begin
        for (int i = 0; i < STORE_BUFFER_ENTRIES; i++) begin
            entries_d[i] = entries_q[i];
            if (drain_free_s && (store_buffer_idx_t'(i) == head_q)) begin
                entries_d[i].state = SB_FREE;
            end else if (alloc_s && (store_buffer_idx_t'(i) == tail_q)) begin
                entries_d[i] = '{state: SB_PENDING, addr: addr_i, data: data_i};
            end else if (discard_hit_s && (store_buffer_idx_t'(i) == store_buffer_idx_discard_i)) begin
                entries_d[i].state = SB_DISCARDED;
            end else if (commit_hit_s && (store_buffer_idx_t'(i) == store_buffer_idx_commit_i)) begin
                entries_d[i].state = SB_COMMITTED;
            end else begin
                entries_d[i] = entries_q[i];
            end
        end
    end

    // Pointer and occupancy next state; allocate and free may coincide.
    always_comb begin
        if (drain_free_s) begin
            head_d = sb_idx_inc(head_q);
        end else begin
            head_d = head_q;
        end
        if (alloc_s) begin
            tail_d = sb_idx_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end
        count_d = count_q + {2'b00, alloc_s} - {2'b00, drain_free_s};
    end

    // State registers; reset drops every entry, committed ones included.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < STORE_BUFFER_ENTRIES; i++) begin
                entries_q[i] <= SB_ENTRY_RESET;
            end
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
            count_q <= SB_COUNT_EMPTY;
        end else begin
            for (int i = 0; i < STORE_BUFFER_ENTRIES; i++) begin
                entries_q[i] <= entries_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule : store_buffer

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
// Directed bench for store_buffer. Expected memory writes are queued when the
// corresponding store is allocated (in allocation order, only for stores the
// sequence will commit); a negedge monitor pops and compares on every accepted
// write and checks that stalled requests hold their address and data.
// -----------------------------------------------------------------------------
module tb_store_buffer;
    import tartaruga_pkg::*;

    logic              clk_i;
    logic              rstn_i;
    exe_to_mem_t       exe_to_mem_i;
    bus32_t            data_i;
    bus32_t            addr_i;
    logic              req_valid_i;
    logic              req_ready_o;
    bus32_t            addr_o;
    bus32_t            data_wr_o;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              store_buffer_commit_i;
    store_buffer_idx_t store_buffer_idx_commit_i;
    logic              store_buffer_discard_i;
    store_buffer_idx_t store_buffer_idx_discard_i;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q [$];

    store_buffer dut (
        .clk_i                      (clk_i),
        .rstn_i                     (rstn_i),
        .exe_to_mem_i               (exe_to_mem_i),
        .data_i                     (data_i),
        .addr_i                     (addr_i),
        .req_valid_i                (req_valid_i),
        .req_ready_o                (req_ready_o),
        .addr_o                     (addr_o),
        .data_wr_o                  (data_wr_o),
        .rsp_valid_o                (rsp_valid_o),
        .rsp_ready_i                (rsp_ready_i),
        .store_buffer_commit_i      (store_buffer_commit_i),
        .store_buffer_idx_commit_i  (store_buffer_idx_commit_i),
        .store_buffer_discard_i     (store_buffer_discard_i),
        .store_buffer_idx_discard_i (store_buffer_idx_discard_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set before this are sampled there.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic alloc(input bus32_t a, input bus32_t d, input bit will_write);
        addr_i      = a;
        data_i      = d;
        req_valid_i = 1'b1;
        if (will_write) exp_q.push_back({a, d});
        cyc();
        req_valid_i = 1'b0;
    endtask

    task automatic commit(input store_buffer_idx_t idx);
        store_buffer_commit_i     = 1'b1;
        store_buffer_idx_commit_i = idx;
        cyc();
        store_buffer_commit_i = 1'b0;
    endtask

    task automatic discard(input store_buffer_idx_t idx);
        store_buffer_discard_i     = 1'b1;
        store_buffer_idx_discard_i = idx;
        cyc();
        store_buffer_discard_i = 1'b0;
    endtask

    task automatic commit_and_discard(input store_buffer_idx_t idx);
        store_buffer_commit_i      = 1'b1;
        store_buffer_idx_commit_i  = idx;
        store_buffer_discard_i     = 1'b1;
        store_buffer_idx_discard_i = idx;
        cyc();
        store_buffer_commit_i  = 1'b0;
        store_buffer_discard_i = 1'b0;
    endtask

    // Monitor: compares accepted writes against the queue, checks held requests.
    initial begin
        logic        hold_prev;
        logic [31:0] hold_addr;
        logic [31:0] hold_data;
        logic [63:0] e;
        hold_prev = 1'b0;
        hold_addr = 32'h0;
        hold_data = 32'h0;
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("held_valid", {31'h0, rsp_valid_o}, 32'h1);
                    check("held_addr", addr_o, hold_addr);
                    check("held_data", data_wr_o, hold_data);
                end
                if (rsp_valid_o && rsp_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got %h@%h, expected no write", data_wr_o, addr_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", addr_o, e[63:32]);
                        check("wr_data", data_wr_o, e[31:0]);
                    end
                end
                hold_prev = rsp_valid_o && !rsp_ready_i;
                hold_addr = addr_o;
                hold_data = data_wr_o;
            end
        end
    end

    initial begin
        rstn_i                     = 1'b0;
        exe_to_mem_i               = '0;
        data_i                     = 32'h0;
        addr_i                     = 32'h0;
        req_valid_i                = 1'b0;
        rsp_ready_i                = 1'b0;
        store_buffer_commit_i      = 1'b0;
        store_buffer_idx_commit_i  = 2'd0;
        store_buffer_discard_i     = 1'b0;
        store_buffer_idx_discard_i = 2'd0;
        cyc();
        cyc();
        check("rst_req_ready", {31'h0, req_ready_o}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        check("rst_addr", addr_o, 32'h0);
        check("rst_data", data_wr_o, 32'h0);
        rstn_i = 1'b1;
        cyc();

        // 1: fill with four stores, one every two cycles
        exe_to_mem_i = '{pc: 32'h0000_0100, rd: 5'd3, mem_we: 1'b1, mem_size: 2'd2};
        alloc(32'h1000_0000, 32'hDEAD_BEEF, 1'b1); cyc();
        alloc(32'h1000_0004, 32'hCAFE_BABE, 1'b1); cyc();
        alloc(32'h1000_0008, 32'hBAAD_F00D, 1'b0); cyc();
        alloc(32'h1000_000C, 32'hFEED_FACE, 1'b1);
        check("full_req_ready", {31'h0, req_ready_o}, 32'h0);
        check("full_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);

        // 2: resolve younger entries while head idx0 is still pending
        commit(2'd1);
        discard(2'd2);
        commit(2'd3);
        check("head_pending_stall", {31'h0, rsp_valid_o}, 32'h0);

        // 3: commit head; request presented and held while memory stalls
        commit(2'd0);
        check("head_commit_valid", {31'h0, rsp_valid_o}, 32'h1);
        check("head_commit_addr", addr_o, 32'h1000_0000);
        check("head_commit_data", data_wr_o, 32'hDEAD_BEEF);
        cyc();
        cyc();

        // 4: two accepted writes, then the discarded entry frees silently
        rsp_ready_i = 1'b1;
        cyc();
        cyc();
        check("discard_head_valid", {31'h0, rsp_valid_o}, 32'h0);
        rsp_ready_i = 1'b0;
        cyc();

        // 5: last committed entry held three cycles, then accepted
        check("last_valid", {31'h0, rsp_valid_o}, 32'h1);
        check("last_addr", addr_o, 32'h1000_000C);
        check("last_data", data_wr_o, 32'hFEED_FACE);
        cyc();
        cyc();
        cyc();
        rsp_ready_i = 1'b1;
        cyc();
        rsp_ready_i = 1'b0;
        check("empty_req_ready", {31'h0, req_ready_o}, 32'h1);
        check("empty_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);

        // 6a: fill, commit all, allocate while draining (pointers wrap)
        alloc(32'h2000_0000, 32'h1111_1111, 1'b1);
        alloc(32'h2000_0004, 32'h2222_2222, 1'b1);
        alloc(32'h2000_0008, 32'h3333_3333, 1'b1);
        alloc(32'h2000_000C, 32'h4444_4444, 1'b1);
        commit(2'd0);
        commit(2'd1);
        commit(2'd2);
        commit(2'd3);
        check("refill_req_ready", {31'h0, req_ready_o}, 32'h0);
        rsp_ready_i = 1'b1;
        cyc();
        check("drain_frees_slot", {31'h0, req_ready_o}, 32'h1);
        alloc(32'h3000_0000, 32'h5555_5555, 1'b1);
        check("alloc_drain_ready", {31'h0, req_ready_o}, 32'h1);
        alloc(32'h3000_0004, 32'h6666_6666, 1'b0);
        commit(2'd0);

        // 6b: commit and discard on the same entry -> discard wins, no write
        commit_and_discard(2'd1);
        cyc();
        check("cd_no_write_valid", {31'h0, rsp_valid_o}, 32'h0);
        check("cd_empty_ready", {31'h0, req_ready_o}, 32'h1);

        // 6c: commit aimed at the entry being allocated is ignored
        addr_i                    = 32'h4000_0000;
        data_i                    = 32'h7777_7777;
        req_valid_i               = 1'b1;
        store_buffer_commit_i     = 1'b1;
        store_buffer_idx_commit_i = 2'd2;
        exp_q.push_back({32'h4000_0000, 32'h7777_7777});
        cyc();
        req_valid_i           = 1'b0;
        store_buffer_commit_i = 1'b0;
        check("alloc_commit_ignored", {31'h0, rsp_valid_o}, 32'h0);
        cyc();
        check("alloc_commit_still_pending", {31'h0, rsp_valid_o}, 32'h0);
        commit(2'd2);
        check("late_commit_valid", {31'h0, rsp_valid_o}, 32'h1);
        check("late_commit_addr", addr_o, 32'h4000_0000);
        cyc();
        check("late_commit_drained", {31'h0, rsp_valid_o}, 32'h0);
        rsp_ready_i = 1'b0;

        // 6d: reset with committed entries outstanding
        alloc(32'h5000_0000, 32'h8888_8888, 1'b0);
        commit(2'd3);
        check("pre_rst_valid", {31'h0, rsp_valid_o}, 32'h1);
        check("pre_rst_addr", addr_o, 32'h5000_0000);
        alloc(32'h5000_0004, 32'h9999_9999, 1'b0);
        rstn_i = 1'b0;
        #1;
        check("async_rst_valid", {31'h0, rsp_valid_o}, 32'h0);
        check("async_rst_ready", {31'h0, req_ready_o}, 32'h1);
        check("async_rst_addr", addr_o, 32'h0);
        check("async_rst_data", data_wr_o, 32'h0);
        cyc();
        cyc();
        rstn_i      = 1'b1;
        rsp_ready_i = 1'b1;
        cyc();
        cyc();
        cyc();
        check("post_rst_valid", {31'h0, rsp_valid_o}, 32'h0);
        check("post_rst_ready", {31'h0, req_ready_o}, 32'h1);
        rsp_ready_i = 1'b0;
        cyc();

        check("expected_writes_left", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_store_buffer
